pyjamask_byte_shell: RTL and testbench

Parametrised byte-serial I/O shell for a parallel Pyjamask round core. It accepts plaintext and key one byte per cycle and holds them in shift registers. It then launches the core with a one-cycle start pulse, captures the core's parallel result, and streams it out byte-serially under receiver back-pressure. It generalises the fixed 96-bit byte interface to BLOCK_BYTES of 12 (Pyjamask-96) or 16 (Pyjamask-128). It adds key reuse across blocks, output back-pressure and a load-error flag.

---
 rtl/pyjamask_byte_shell_if.sv | 31 +++
 rtl/pyjamask_byte_shell.sv | 153 +++++++++++++++
 tb/tb_pyjamask_byte_shell.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pyjamask_byte_shell_if.sv
// Byte-serial host port and parallel core port of the Pyjamask byte shell.
// The shell uses the slave view; the host/core side uses the master view.
interface pyjamask_byte_shell_if #(
  parameter int unsigned BLOCK_BYTES = 12
);
  logic                       load;
  logic [7:0]                 byte_in;
  logic [7:0]                 byte_key_in;
  logic                       key_keep;
  logic                       start;
  logic                       ready;
  logic                       err;
  logic                       core_start;
  logic [8*BLOCK_BYTES-1:0]   core_state_in;
  logic [127:0]               core_key;
  logic                       core_done;
  logic [8*BLOCK_BYTES-1:0]   core_state_out;
  logic                       valid;
  logic [7:0]                 byte_out;
  logic                       out_ready;

  modport slave (
    input  load, byte_in, byte_key_in, key_keep, start, core_done, core_state_out, out_ready,
    output ready, err, core_start, core_state_in, core_key, valid, byte_out
  );

  modport master (
    output load, byte_in, byte_key_in, key_keep, start, core_done, core_state_out, out_ready,
    input  ready, err, core_start, core_state_in, core_key, valid, byte_out
  );
endinterface

// File: rtl/pyjamask_byte_shell.sv
// Byte-serial load/drain shell around a parallel Pyjamask round core, with key reuse,
// output back-pressure and an early-start error pulse.
module pyjamask_byte_shell #(
  parameter int unsigned BLOCK_BYTES = 12,
  parameter int unsigned KEY_BYTES   = 16
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  pyjamask_byte_shell_if.slave   bus
);

  localparam int unsigned BW = 8 * BLOCK_BYTES;
  localparam int unsigned CW = $clog2(KEY_BYTES + 1);

  localparam logic [CW-1:0] BlockCnt = CW'(BLOCK_BYTES);
  localparam logic [CW-1:0] KeyCnt   = CW'(KEY_BYTES);
  localparam logic [CW-1:0] LastOut  = CW'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StArmed, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic            keep_q, keep_d;
  logic            key_valid_q, key_valid_d;
  logic [CW-1:0]   lcnt_q, lcnt_d;
  logic [CW-1:0]   ocnt_q, ocnt_d;
  logic [BW-1:0]   pt_q, pt_d;
  logic [127:0]    key_q, key_d;
  logic [BW-1:0]   out_q, out_d;
  logic            err_q, err_d;
  logic            core_start_q, core_start_d;

  logic            keep_eff;
  logic            do_load;
  logic [CW-1:0]   load_len;
  logic [CW-1:0]   lcnt_inc;

  always_comb begin
    state_d      = state_q;
    keep_d       = keep_q;
    key_valid_d  = key_valid_q;
    lcnt_d       = lcnt_q;
    ocnt_d       = ocnt_q;
    pt_d         = pt_q;
    key_d        = key_q;
    out_d        = out_q;
    err_d        = 1'b0;
    core_start_d = 1'b0;
    keep_eff     = keep_q;
    do_load      = 1'b0;
    load_len     = KeyCnt;
    lcnt_inc     = lcnt_q + CW'(1);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          err_d = 1'b1;
        end else if (bus.load) begin
          // Key reuse is only honoured once a complete key has been stored.
          keep_eff = bus.key_keep & key_valid_q;
          keep_d   = keep_eff;
          state_d  = StLoad;
          do_load  = 1'b1;
        end
      end
      StLoad: begin
        if (bus.start) begin
          err_d = 1'b1;
        end else if (bus.load) begin
          do_load = 1'b1;
        end
      end
      StArmed: begin
        if (bus.start) begin
          core_start_d = 1'b1;
          state_d      = StRun;
        end
      end
      StRun: begin
        if (bus.core_done) begin
          out_d   = bus.core_state_out;
          ocnt_d  = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.out_ready) begin
          out_d  = out_q << 8;
          ocnt_d = ocnt_q + CW'(1);
          if (ocnt_q == LastOut) begin
            state_d = StIdle;
            lcnt_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      load_len = keep_eff ? BlockCnt : KeyCnt;
      // Plaintext stops shifting once the block is full; the key may run longer.
      if (lcnt_q < BlockCnt) begin
        pt_d = {pt_q[BW-9:0], bus.byte_in};
      end
      if (!keep_eff) begin
        key_d = {key_q[119:0], bus.byte_key_in};
      end
      lcnt_d = lcnt_inc;
      if (lcnt_inc == load_len) begin
        state_d = StArmed;
        if (!keep_eff) begin
          key_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      keep_q       <= 1'b0;
      key_valid_q  <= 1'b0;
      lcnt_q       <= '0;
      ocnt_q       <= '0;
      pt_q         <= '0;
      key_q        <= '0;
      out_q        <= '0;
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      keep_q       <= keep_d;
      key_valid_q  <= key_valid_d;
      lcnt_q       <= lcnt_d;
      ocnt_q       <= ocnt_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      out_q        <= out_d;
      err_q        <= err_d;
      core_start_q <= core_start_d;
    end
  end

  always_comb begin
    bus.ready         = (state_q == StIdle);
    bus.valid         = (state_q == StDrain);
    bus.byte_out      = out_q[BW-1 -: 8];
    bus.err           = err_q;
    bus.core_start    = core_start_q;
    bus.core_state_in = pt_q;
    bus.core_key      = key_q;
  end

endmodule

// File: tb/tb_pyjamask_byte_shell.sv
// Randomized directed bench for pyjamask_byte_shell (12- and 16-byte instances) with a stub
// core and a block-level reference model of the expected output stream.
module tb_pyjamask_byte_shell;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  bit         sel;
  logic       t_load, t_keep, t_start, t_ord;
  logic [7:0] t_byte, t_kbyte;

  int errors = 0;
  int checks = 0;

  pyjamask_byte_shell_if #(.BLOCK_BYTES(12)) ia ();
  pyjamask_byte_shell_if #(.BLOCK_BYTES(16)) ib ();

  assign ia.load        = t_load & ~sel;
  assign ia.start       = t_start & ~sel;
  assign ia.byte_in     = t_byte;
  assign ia.byte_key_in = t_kbyte;
  assign ia.key_keep    = t_keep;
  assign ia.out_ready   = t_ord;
  assign ib.load        = t_load & sel;
  assign ib.start       = t_start & sel;
  assign ib.byte_in     = t_byte;
  assign ib.byte_key_in = t_kbyte;
  assign ib.key_keep    = t_keep;
  assign ib.out_ready   = t_ord;

  pyjamask_byte_shell #(.BLOCK_BYTES(12), .KEY_BYTES(16)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ia)
  );

  pyjamask_byte_shell #(.BLOCK_BYTES(16), .KEY_BYTES(16)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ib)
  );

  // Stub core: result = state XOR top key bytes, done three cycles after core_start.
  logic [2:0] sra, srb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sra <= '0;
      srb <= '0;
    end else begin
      sra <= {sra[1:0], ia.core_start};
      srb <= {srb[1:0], ib.core_start};
    end
  end
  assign ia.core_done      = sra[2];
  assign ia.core_state_out = ia.core_state_in ^ ia.core_key[127 -: 96];
  assign ib.core_done      = srb[2];
  assign ib.core_state_out = ib.core_state_in ^ ib.core_key;

  logic         o_ready, o_err, o_cs, o_valid;
  logic [7:0]   o_byte;
  logic [127:0] o_state, o_key;
  assign o_ready = sel ? ib.ready      : ia.ready;
  assign o_err   = sel ? ib.err        : ia.err;
  assign o_cs    = sel ? ib.core_start : ia.core_start;
  assign o_valid = sel ? ib.valid      : ia.valid;
  assign o_byte  = sel ? ib.byte_out   : ia.byte_out;
  assign o_state = sel ? ib.core_state_in : {ia.core_state_in, 32'h0};
  assign o_key   = sel ? ib.core_key   : ia.core_key;

  // Reference model: stored key and whether a full key has been loaded, per instance.
  logic [127:0] mkey [2];
  bit           mkv  [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_model();
    mkey[0] = '0;
    mkey[1] = '0;
    mkv[0]  = 1'b0;
    mkv[1]  = 1'b0;
  endtask

  // One complete block: load, optional early start, launch, drain (with optional reset).
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input bit keep,
                           input int bp, input int early, input int rst_at);
    int           bb, len, i, k, cyc;
    bit           ek;
    logic [127:0] m, exp_pt, expct;
    bb     = sel ? 16 : 12;
    ek     = keep && mkv[sel];
    len    = ek ? bb : 16;
    m      = '1;
    m      = m << (8 * (16 - bb));
    exp_pt = pt & m;
    chk("ready_before_load", 128'(o_ready), 128'(1));

    i = 0;
    while (i < len) begin
      if (i == early) begin
        t_load  = 1'b0;
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        chk("early_err", 128'(o_err), 128'(1));
        chk("early_no_core_start", 128'(o_cs), 128'(0));
        chk("early_still_loading", 128'(o_ready), 128'(0));
        tick();
        chk("err_single_cycle", 128'(o_err), 128'(0));
      end
      if ($urandom_range(0, 3) == 0) begin
        t_load = 1'b0;
        tick();
      end
      t_load  = 1'b1;
      t_byte  = (i < bb) ? pt[127 - 8*i -: 8] : 8'($urandom);
      t_kbyte = key[127 - 8*i -: 8];
      t_keep  = (i == 0) ? keep : 1'($urandom);
      tick();
      i++;
    end
    // One extra load in ARMED must be ignored.
    t_byte  = 8'($urandom);
    t_kbyte = 8'($urandom);
    t_keep  = 1'($urandom);
    tick();
    t_load = 1'b0;
    if (!ek) begin
      mkey[sel] = key;
      mkv[sel]  = 1'b1;
    end
    chk("armed_not_ready", 128'(o_ready), 128'(0));
    chk("core_state_in", o_state, exp_pt);
    chk("core_key", o_key, mkey[sel]);

    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    chk("core_start_pulse", 128'(o_cs), 128'(1));
    tick();
    chk("core_start_width", 128'(o_cs), 128'(0));
    chk("state_in_stable_run", o_state, exp_pt);
    cyc = 1;
    while (!o_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("start_to_valid_latency", 128'(cyc), 128'(4));

    expct = exp_pt ^ (mkey[sel] & m);
    k   = 0;
    cyc = 0;
    while (k < bb && cyc < 200) begin
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_valid", 128'(o_valid), 128'(0));
        chk("reset_ready", 128'(o_ready), 128'(1));
        chk("reset_key", o_key, 128'(0));
        reset_model();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      case (bp)
        0:       t_ord = 1'b1;
        1:       t_ord = (cyc % 2 == 0);
        default: t_ord = 1'($urandom_range(0, 1));
      endcase
      chk("valid_in_drain", 128'(o_valid), 128'(1));
      chk($sformatf("out_byte%0d", k), 128'(o_byte), 128'(expct[127 - 8*k -: 8]));
      if (t_ord) k++;
      tick();
      cyc++;
    end
    chk("bytes_accepted", 128'(k), 128'(bb));
    if (bp == 0) chk("stream_cycles", 128'(cyc), 128'(bb));
    chk("valid_after_drain", 128'(o_valid), 128'(0));
    chk("ready_after_drain", 128'(o_ready), 128'(1));
    chk("key_retained", o_key, mkey[sel]);
  endtask

  initial begin
    logic [127:0] kbase, rk, rp;
    sel     = 1'b0;
    t_load  = 1'b0;
    t_keep  = 1'b0;
    t_start = 1'b0;
    t_ord   = 1'b0;
    t_byte  = '0;
    t_kbyte = '0;
    rst_n   = 1'b0;
    reset_model();
    tick();
    tick();
    chk("rst_ready", 128'(o_ready), 128'(1));
    chk("rst_err", 128'(o_err), 128'(0));
    chk("rst_core_start", 128'(o_cs), 128'(0));
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_byte_out", 128'(o_byte), 128'(0));
    chk("rst_state_in", o_state, 128'(0));
    chk("rst_core_key", o_key, 128'(0));
    rst_n = 1'b1;
    tick();

    kbase = 128'h00112233445566778899aabbccddeeff;
    // Basic stream: expected bytes 50 68 48 52 29 34 15 1c b1 af 90 92.
    run_block(kbase, {96'h50796a616d61736b39363a29, 32'h0}, 1'b0, 0, -1, -1);
    // Key reuse with all-zero plaintext: the output is the stored key's top bytes.
    rk = {$urandom, $urandom, $urandom, $urandom};
    run_block(rk, 128'h0, 1'b1, 0, -1, -1);
    // Back-pressure, alternating out_ready.
    rp = {$urandom, $urandom, $urandom, $urandom};
    run_block(rk, rp, 1'b1, 1, -1, -1);
    // Early start after 10 loads.
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    run_block(rk, rp, 1'b0, 2, 10, -1);
    // Reset after five output bytes, then key_keep must be treated as 0.
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    run_block(rk, rp, 1'b0, 0, -1, 5);
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    run_block(rk, rp, 1'b1, 0, -1, -1);
    for (int r = 0; r < 4; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run_block(rk, rp, 1'($urandom), int'($urandom_range(0, 2)), -1, -1);
    end

    // 16-byte instance: plaintext equal to key gives an all-zero output.
    sel = 1'b1;
    tick();
    run_block(kbase, kbase, 1'b0, 0, -1, -1);
    rp = {$urandom, $urandom, $urandom, $urandom};
    run_block(128'h0, rp, 1'b1, 2, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
